// File: rtl/fnv_1a_32_checker.sv
// FNV-1a 32-bit frame checker: hashes the payload of each framed byte stream,
// captures the trailing little-endian 4-byte digest and reports match/mismatch.
module fnv_1a_32_checker #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             done,
  output logic             match,
  output logic             err_len,
  output logic [31:0]      hash_out,
  output logic [LEN_W-1:0] rx_count
);

  localparam logic [31:0]      FNV_OFFSET = 32'h811C9DC5;
  localparam logic [31:0]      FNV_PRIME  = 32'h01000193;
  localparam logic [LEN_W-1:0] LAST_IDX   = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_DIGEST  = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  // One FNV-1a round: xor the byte into the low octet, multiply by the prime.
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'h000000, b};
    return x * FNV_PRIME;
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_hash;
  logic [LEN_W-1:0] r_count;
  logic [1:0]       r_idx;
  logic [31:0]      r_expected;
  logic             r_err;
  logic             r_done;
  logic             r_match;
  logic             r_err_len;
  logic [31:0]      r_hash_out;
  logic [LEN_W-1:0] r_rx_count;

  logic             w_ready;
  logic             w_accept;
  logic [31:0]      w_digest_full;

  // Ready depends on the state alone; only the one-cycle verdict slot stalls input.
  assign w_ready       = (r_state != ST_RESULT);
  assign w_accept      = in_valid && w_ready;
  // The fourth digest byte is merged on the fly so the verdict is ready with done.
  assign w_digest_full = {in_data, r_expected[23:0]};

  assign in_ready = w_ready;
  assign done     = r_done;
  assign match    = r_match;
  assign err_len  = r_err_len;
  assign hash_out = r_hash_out;
  assign rx_count = r_rx_count;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_PAYLOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode for payload, overflow flush, digest capture and verdict.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PAYLOAD: begin
        if (w_accept && in_last) begin
          w_state_next = ST_DIGEST;
        end else if (w_accept && (r_count == LAST_IDX)) begin
          w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_PAYLOAD;
        end
      end
      ST_FLUSH: begin
        if (w_accept && in_last) begin
          w_state_next = ST_DIGEST;
        end else begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_DIGEST: begin
        if (w_accept && (r_idx == 2'd3)) begin
          w_state_next = ST_RESULT;
        end else begin
          w_state_next = ST_DIGEST;
        end
      end
      ST_RESULT: begin
        w_state_next = ST_PAYLOAD;
      end
      default: begin
        w_state_next = ST_PAYLOAD;
      end
    endcase
  end

  // Datapath: hash/count accumulation, digest capture and registered verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hash     <= FNV_OFFSET;
      r_count    <= '0;
      r_idx      <= 2'd0;
      r_expected <= 32'h00000000;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_err_len  <= 1'b0;
      r_hash_out <= 32'h00000000;
      r_rx_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_PAYLOAD: begin
          if (w_accept) begin
            r_hash  <= fnv_step(r_hash, in_data);
            r_count <= r_count + LEN_W'(1);
            if (!in_last && (r_count == LAST_IDX)) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Overflow bytes are consumed without touching hash or count.
        end
        ST_DIGEST: begin
          if (w_accept) begin
            r_expected[{r_idx, 3'b000} +: 8] <= in_data;
            r_idx                            <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_done     <= 1'b1;
              r_match    <= (r_hash == w_digest_full) && !r_err;
              r_err_len  <= r_err;
              r_hash_out <= r_hash;
              r_rx_count <= r_count;
            end
          end
        end
        ST_RESULT: begin
          r_hash     <= FNV_OFFSET;
          r_count    <= '0;
          r_idx      <= 2'd0;
          r_expected <= 32'h00000000;
          r_err      <= 1'b0;
        end
        default: begin
          r_hash     <= FNV_OFFSET;
          r_count    <= '0;
          r_idx      <= 2'd0;
          r_expected <= 32'h00000000;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnv_1a_32_checker.sv
// Self-checking bench for fnv_1a_32_checker: directed vectors plus random
// framed traffic compared against a queue-based FNV-1a reference model.
module tb_fnv_1a_32_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        done;
  logic        match;
  logic        err_len;
  logic [31:0] hash_out;
  logic [6:0]  rx_count;

  typedef struct packed {
    logic        m;
    logic        e;
    logic [31:0] h;
    logic [6:0]  c;
  } verdict_t;

  int       errors = 0;
  int       checks = 0;
  int       dbl_done = 0;
  int       bad_ready = 0;
  logic     prev_done = 1'b0;
  verdict_t cap_q[$];

  fnv_1a_32_checker #(.MAX_LEN(64), .LEN_W(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .done     (done),
    .match    (match),
    .err_len  (err_len),
    .hash_out (hash_out),
    .rx_count (rx_count)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: capture each verdict, flag double pulses and ready outside RESULT.
  always @(negedge clk) begin
    verdict_t v;
    if (done) begin
      v = {match, err_len, hash_out, rx_count};
      cap_q.push_back(v);
    end
    if (done && prev_done) dbl_done++;
    if (!reset && (in_ready !== !done)) bad_ready++;
    prev_done = done;
  end

  // Reference: FNV-1a over the kept prefix; overflow frames never match.
  function automatic verdict_t model(input logic [7:0] pl[$], input logic [31:0] dig);
    verdict_t    v;
    logic [31:0] h;
    int          n;
    n   = pl.size();
    v.e = (n > 64);
    v.c = v.e ? 7'd64 : 7'(n);
    h   = 32'h811C9DC5;
    for (int i = 0; i < int'(v.c); i++) h = (h ^ {24'd0, pl[i]}) * 32'h01000193;
    v.h = h;
    v.m = !v.e && (h == dig);
    return v;
  endfunction

  task automatic put_byte(input logic [7:0] b, input logic l);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    while (!acc && t < 20) begin
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) begin
      errors++; checks++;
      $display("FAIL accept: in_ready=0 for 20 cycles, required 1");
    end
  endtask

  task automatic idle_gap(input int gap_pct);
    if ($urandom_range(0, 99) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Sends payload then digest; in_valid stays high after the last byte.
  task automatic send_frame(input logic [7:0] pl[$], input logic [31:0] dig, input int gap_pct);
    for (int i = 0; i < pl.size(); i++) begin
      if (i > 0) idle_gap(gap_pct);
      put_byte(pl[i], (i == pl.size() - 1) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      idle_gap(gap_pct);
      put_byte(dig[8*k +: 8], 1'($urandom));
    end
  endtask

  task automatic run_one(input logic [7:0] pl[$], input logic [31:0] dig, input int gap_pct,
                         output verdict_t v, output bit ok);
    int n0;
    int t;
    n0 = cap_q.size();
    send_frame(pl, dig, gap_pct);
    in_valid = 1'b0;
    t = 0;
    while (cap_q.size() <= n0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    ok = (cap_q.size() > n0);
    if (ok) begin
      v = cap_q[n0];
    end else begin
      v = '0;
      errors++; checks++;
      $display("FAIL verdict_timeout: no done within 10 cycles, required a pulse");
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({match, err_len} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {match, err_len}); end
    checks++; if (hash_out !== 32'h0) begin errors++; $display("FAIL reset_hash: got %h want 00000000", hash_out); end
    checks++; if (rx_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rx_count); end
  endtask

  task automatic test_vector_a;
    logic [7:0] pl[$];
    verdict_t   v;
    bit         ok;
    pl = '{8'h61};
    run_one(pl, 32'hE40C292C, 0, v, ok);
    if (ok) begin
      checks++; if (v.m !== 1'b1) begin errors++; $display("FAIL a_match: got %b want 1", v.m); end
      checks++; if (v.h !== 32'hE40C292C) begin errors++; $display("FAIL a_hash: got %h want e40c292c", v.h); end
      checks++; if (v.c !== 7'd1 || v.e !== 1'b0) begin errors++; $display("FAIL a_count: got c=%0d e=%b want c=1 e=0", v.c, v.e); end
    end
  endtask

  task automatic test_foobar;
    logic [7:0] pl[$];
    verdict_t   v;
    bit         ok;
    int         n0;
    pl = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    run_one(pl, 32'hBF9CF968, 0, v, ok);
    if (ok) begin
      checks++; if (v.m !== 1'b1 || v.h !== 32'hBF9CF968 || v.c !== 7'd6) begin
        errors++; $display("FAIL foobar_ok: got m=%b h=%h c=%0d want m=1 h=bf9cf968 c=6", v.m, v.h, v.c);
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (hash_out !== 32'hBF9CF968 || match !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL foobar_hold: got h=%h m=%b d=%b want h=bf9cf968 m=1 d=0", hash_out, match, done);
    end
    n0 = cap_q.size();
    run_one(pl, 32'hBF9CF969, 0, v, ok);
    if (ok) begin
      checks++; if (v.m !== 1'b0 || v.h !== 32'hBF9CF968 || v.e !== 1'b0) begin
        errors++; $display("FAIL foobar_bad: got m=%b h=%h e=%b want m=0 h=bf9cf968 e=0", v.m, v.h, v.e);
      end
    end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (cap_q.size() !== n0 + 1) begin errors++; $display("FAIL foobar_pulses: got %0d want 1", cap_q.size() - n0); end
  endtask

  task automatic test_length_limits;
    logic [7:0] pl[$];
    verdict_t   v, exp;
    bit         ok;
    pl = {};
    for (int i = 0; i < 70; i++) pl.push_back(8'($urandom));
    exp = model(pl, 32'h0);
    // Digest equals the prefix hash; the overflow must still force a mismatch.
    run_one(pl, exp.h, 25, v, ok);
    if (ok) begin
      checks++; if (v.e !== 1'b1 || v.m !== 1'b0 || v.c !== 7'd64) begin
        errors++; $display("FAIL overlen: got e=%b m=%b c=%0d want e=1 m=0 c=64", v.e, v.m, v.c);
      end
      checks++; if (v.h !== exp.h) begin errors++; $display("FAIL overlen_hash: got %h want %h", v.h, exp.h); end
    end
    pl = '{8'h61};
    run_one(pl, 32'hE40C292C, 0, v, ok);
    if (ok) begin
      checks++; if (v.m !== 1'b1 || v.e !== 1'b0) begin errors++; $display("FAIL after_overlen: got m=%b e=%b want m=1 e=0", v.m, v.e); end
    end
    pl = {};
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    exp = model(pl, 32'h0);
    run_one(pl, exp.h, 0, v, ok);
    if (ok) begin
      checks++; if (v.e !== 1'b0 || v.m !== 1'b1 || v.c !== 7'd64 || v.h !== exp.h) begin
        errors++; $display("FAIL exact_max: got e=%b m=%b c=%0d h=%h want e=0 m=1 c=64 h=%h", v.e, v.m, v.c, v.h, exp.h);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl[$];
    logic [31:0] dig;
    verdict_t   exp_q[$];
    verdict_t   e0;
    int         n0;
    int         t;
    n0 = cap_q.size();
    pl = '{8'h61};
    send_frame(pl, 32'hE40C292C, 40);
    exp_q.push_back(model(pl, 32'hE40C292C));
    for (int f = 0; f < 12; f++) begin
      pl = {};
      for (int i = 0; i < int'($urandom_range(1, 70)); i++) pl.push_back(8'($urandom));
      e0  = model(pl, 32'h0);
      dig = $urandom_range(0, 1) ? e0.h : $urandom;
      exp_q.push_back(model(pl, dig));
      send_frame(pl, dig, 30);
    end
    in_valid = 1'b0;
    t = 0;
    while (cap_q.size() < n0 + exp_q.size() && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    checks++; if (cap_q.size() !== n0 + exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d verdicts want %0d", cap_q.size() - n0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && (n0 + i) < cap_q.size(); i++) begin
      checks++; if (cap_q[n0 + i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_frame%0d: got m=%b e=%b h=%h c=%0d want m=%b e=%b h=%h c=%0d", i,
          cap_q[n0+i].m, cap_q[n0+i].e, cap_q[n0+i].h, cap_q[n0+i].c, exp_q[i].m, exp_q[i].e, exp_q[i].h, exp_q[i].c);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] pl[$];
    verdict_t   v;
    bit         ok;
    int         n0;
    n0 = cap_q.size();
    put_byte(8'h66, 1'b0);
    put_byte(8'h6F, 1'b0);
    put_byte(8'h6F, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({done, match, err_len} !== 3'b000 || hash_out !== 32'h0 || rx_count !== 7'd0) begin
      errors++; $display("FAIL midreset_outputs: got d=%b m=%b e=%b h=%h c=%0d want all zero", done, match, err_len, hash_out, rx_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    pl = '{8'h61};
    run_one(pl, 32'hE40C292C, 0, v, ok);
    checks++; if (cap_q.size() !== n0 + 1) begin errors++; $display("FAIL midreset_pulses: got %0d want 1", cap_q.size() - n0); end
    if (ok) begin
      checks++; if (v.m !== 1'b1 || v.h !== 32'hE40C292C || v.c !== 7'd1) begin
        errors++; $display("FAIL midreset_a: got m=%b h=%h c=%0d want m=1 h=e40c292c c=1", v.m, v.h, v.c);
      end
    end
  endtask

  task automatic test_protocol;
    checks++; if (dbl_done !== 0) begin errors++; $display("FAIL done_width: got %0d double pulses want 0", dbl_done); end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL ready_timing: got %0d bad cycles want 0", bad_ready); end
  endtask

  // Hard stop in case a wait is never satisfied.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_vector_a();
    test_foobar();
    test_length_limits();
    test_back_to_back();
    test_reset_midframe();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
